fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have one parameter: RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit, the reset, which is synchronous and active-low.
REQ-004 The module SHALL have port imem_req_valid, output, 1 bit, which signals a fetch request.
REQ-005 The module SHALL have port imem_req_ready, input, 1 bit, which signals that memory accepts the request.
REQ-006 The module SHALL have port imem_addr, output, 32 bits, the word-aligned fetch address.
REQ-007 The module SHALL have port imem_rsp_valid, input, 1 bit, which signals that response data is valid; it is never back-pressured.
REQ-008 The module SHALL have port imem_rsp_data, input, 32 bits, the fetched instruction word.
REQ-009 The module SHALL have port if_valid, output, 1 bit, which signals that the instruction to decode/imm_gen is valid.
REQ-010 The module SHALL have port if_ready, input, 1 bit, which signals that decode accepts the instruction.
REQ-011 The module SHALL have port if_instr, output, 32 bits, the instruction word fed to decode and imm_gen.
REQ-012 The module SHALL have port if_pc, output, 32 bits, the address of if_instr.
REQ-013 The module SHALL have port redirect_valid, input, 1 bit, a branch/jump-taken pulse from the execute stage.
REQ-014 The module SHALL have port redirect_pc, input, 32 bits, the target (pc + imm_out computed downstream).
REQ-015 The module SHALL have port misalign_err, output, 1 bit, a one-cycle pulse when redirect_pc[1:0] != 0.

Function
REQ-016 The FSM SHALL have exactly four states: S_REQ, S_WAIT, S_OUT and S_DROP.
REQ-017 In S_REQ, imem_req_valid SHALL be 1 and imem_addr SHALL equal the PC register; when req_valid && req_ready, the next state SHALL be S_WAIT; otherwise the FSM SHALL stay in S_REQ.
REQ-018 In S_WAIT, when imem_rsp_valid is 1, if_instr SHALL be loaded with rsp_data, if_pc SHALL be loaded with the PC, and the next state SHALL be S_OUT; if_valid SHALL be 1 in the following cycle (1-cycle latency).
REQ-019 In S_OUT, if_valid SHALL be 1 and if_instr/if_pc SHALL be held stable until if_valid && if_ready; on that handshake the PC SHALL become PC+4 and the next state SHALL be S_REQ.
REQ-020 Request-to-decode throughput SHALL be at most one instruction per 3 cycles, with one outstanding memory request maximum.
REQ-021 PC+4 SHALL be computed modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-022 On redirect_valid, the PC SHALL load {redirect_pc[31:2],2'b00} in every state, and redirect SHALL take priority over the PC+4 increment.
REQ-023 Redirect in S_REQ without a same-cycle accept SHALL keep the FSM in S_REQ, and the new address SHALL appear next cycle.
REQ-024 Redirect in S_REQ with a same-cycle accept, or in S_WAIT without rsp_valid, SHALL move the FSM to S_DROP.
REQ-025 Redirect in S_WAIT with a same-cycle rsp_valid SHALL discard the response and move the FSM to S_REQ.
REQ-026 Redirect in S_OUT SHALL clear if_valid next cycle regardless of if_ready, and the FSM SHALL go to S_REQ.
REQ-027 In S_DROP, imem_req_valid SHALL be 0; rsp_valid SHALL be discarded and the FSM SHALL go to S_REQ; a further redirect in S_DROP SHALL update the PC and stay in S_DROP.
REQ-028 misalign_err SHALL pulse exactly one cycle after each redirect with redirect_pc[1:0] != 0.
REQ-029 imem_rsp_valid SHALL be ignored in S_REQ and S_OUT.

Reset
REQ-030 While rst_n is 0 at a clock edge, the PC SHALL become RESET_PC and the state SHALL become S_REQ.
REQ-031 While rst_n is 0 at a clock edge, if_valid, misalign_err and imem_req_valid SHALL be 0, and if_instr and if_pc SHALL be 0.
REQ-032 Reset asserted mid-transaction SHALL abandon any outstanding request, and no response arriving after reset release SHALL be forwarded unless it answers a post-reset request.

Structure
REQ-033 The fetch_state_t enum (S_REQ, S_WAIT, S_OUT, S_DROP) and the PC_STEP constant (32'd4) SHALL reside in the shared core package alongside the IMM_* selectors.
REQ-034 The module SHALL have no sub-modules; the PC register and FSM SHALL be inline.

Verification
REQ-035 Reset with RESET_PC=0 and memory always ready at 1-cycle latency, returning 32'h00A00093 then 32'h00108113 -> imem_addr 0 then 4; if_pc 0 then 4; if_valid first high 3 cycles after rst_n rises.
REQ-036 if_ready held 0 for 5 cycles in S_OUT -> if_instr/if_pc stable; no new imem_req_valid until the handshake.
REQ-037 Redirect to 32'h40 in S_WAIT, stale rsp 32'hDEADBEEF arriving 2 cycles later -> DEADBEEF never on if_instr; next imem_addr 32'h40.
REQ-038 Redirect to 32'h22 -> misalign_err one-cycle pulse; next fetch address 32'h20.
REQ-039 PC at 32'hFFFF_FFFC with fetch completed -> next imem_addr 32'h0000_0000.
REQ-040 rst_n low for 1 cycle during S_WAIT -> if_valid 0 and imem_addr RESET_PC in the cycle after release.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared core package: fetch FSM state encoding, PC step size, immediate
// format selectors used by imm_gen, and a small PC alignment helper.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // present a request at the PC
        S_WAIT = 2'd1,  // one request outstanding, waiting for its response
        S_OUT  = 2'd2,  // instruction presented to decode
        S_DROP = 2'd3   // outstanding response belongs to a squashed path
    } fetch_state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_t;

    // Force a target address onto a word boundary.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: a single-outstanding-request fetch FSM with an
// inline PC register.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   imem_req_valid/ready/addr  request channel to instruction memory
//   imem_rsp_valid/data        response channel (never back-pressured)
//   if_valid/ready/instr/pc    instruction handed to decode / imm_gen
//   redirect_valid/pc          taken branch/jump from execute
//   misalign_err               one-cycle pulse after a misaligned redirect
// All outputs are registered.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misalign_err
);

    fetch_state_t state_r;
    fetch_state_t state_next_s;
    logic [31:0]  pc_r;
    logic [31:0]  pc_next_s;
    logic         load_if_s;
    logic         req_valid_r;
    logic         if_valid_r;
    logic [31:0]  if_instr_r;
    logic [31:0]  if_pc_r;
    logic         misalign_r;

    // Next-state, next-PC and instruction-capture decode.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        load_if_s    = 1'b0;
        case (state_r)
            S_REQ: begin
                // A redirect with a same-cycle accept leaves a response
                // for the old path in flight, which must be dropped.
                if (req_valid_r && imem_req_ready) begin
                    state_next_s = redirect_valid ? S_DROP : S_WAIT;
                end else begin
                    state_next_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (redirect_valid) begin
                        state_next_s = S_REQ;
                    end else begin
                        load_if_s    = 1'b1;
                        state_next_s = S_OUT;
                    end
                end else if (redirect_valid) begin
                    state_next_s = S_DROP;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    state_next_s = S_REQ;
                end else if (if_valid_r && if_ready) begin
                    pc_next_s    = pc_r + PC_STEP;
                    state_next_s = S_REQ;
                end else begin
                    state_next_s = S_OUT;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid) begin
                    state_next_s = S_REQ;
                end else begin
                    state_next_s = S_DROP;
                end
            end
            default: begin
                state_next_s = S_REQ;
            end
        endcase
        // Redirect wins over the sequential increment in every state.
        if (redirect_valid) begin
            pc_next_s = align_pc(redirect_pc);
        end else begin
            pc_next_s = pc_next_s;
        end
    end

    // State, PC and registered output update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= S_REQ;
            pc_r        <= RESET_PC;
            req_valid_r <= 1'b0;
            if_valid_r  <= 1'b0;
            if_instr_r  <= 32'h0000_0000;
            if_pc_r     <= 32'h0000_0000;
            misalign_r  <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            pc_r        <= pc_next_s;
            // Output valids are derived from the next state so they line up
            // with the state they describe.
            req_valid_r <= (state_next_s == S_REQ);
            if_valid_r  <= (state_next_s == S_OUT);
            misalign_r  <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            if (load_if_s) begin
                if_instr_r <= imem_rsp_data;
                if_pc_r    <= pc_r;
            end else begin
                if_instr_r <= if_instr_r;
                if_pc_r    <= if_pc_r;
            end
        end
    end

    assign imem_req_valid = req_valid_r;
    assign imem_addr      = pc_r;
    assign if_valid       = if_valid_r;
    assign if_instr       = if_instr_r;
    assign if_pc          = if_pc_r;
    assign misalign_err   = misalign_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle-by-cycle vector table covering
// reset, normal fetch, decode stall, all redirect cases and misalignment,
// followed by hand-written sequences for PC wrap and mid-transaction reset.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misalign_err   (misalign_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic        rst;
        logic        rdv;
        logic [31:0] rdpc;
        logic        rqr;
        logic        rsv;
        logic [31:0] rsd;
        logic        ifr;
        logic        e_rqv;
        logic [31:0] e_addr;
        logic        e_ifv;
        logic [31:0] e_ins;
        logic [31:0] e_pc;
        logic        e_mis;
    } vec_t;

    localparam int NV = 31;
    vec_t tbl [NV];

    localparam logic [31:0] I0 = 32'h00A0_0093;
    localparam logic [31:0] I1 = 32'h0010_8113;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] I2 = 32'h0000_0013;
    localparam logic [31:0] I3 = 32'h1234_5678;

    function automatic vec_t mk(
        input logic rst, input logic rdv, input logic [31:0] rdpc,
        input logic rqr, input logic rsv, input logic [31:0] rsd, input logic ifr,
        input logic e_rqv, input logic [31:0] e_addr, input logic e_ifv,
        input logic [31:0] e_ins, input logic [31:0] e_pc, input logic e_mis);
        vec_t v;
        v = {rst, rdv, rdpc, rqr, rsv, rsd, ifr, e_rqv, e_addr, e_ifv, e_ins, e_pc, e_mis};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample outputs 1 ns after the edge.
    task automatic cyc(input logic rst, input logic rdv, input logic [31:0] rdpc,
                       input logic rqr, input logic rsv, input logic [31:0] rsd,
                       input logic ifr);
        rst_n          = rst;
        redirect_valid = rdv;
        redirect_pc    = rdpc;
        imem_req_ready = rqr;
        imem_rsp_valid = rsv;
        imem_rsp_data  = rsd;
        if_ready       = ifr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset, first two fetches with 1-cycle memory
        tbl[0]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 32'h0,   1'b0);
        tbl[1]  = mk(1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 32'h0,   1'b0);
        tbl[2]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0,   1'b0, 32'h0, 32'h0,   1'b0);
        tbl[3]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 32'h0,   1'b0);
        tbl[4]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, I0,    1'b0, 1'b0, 32'h0,   1'b1, I0,    32'h0,   1'b0);
        tbl[5]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4,   1'b0, I0,    32'h0,   1'b0);
        tbl[6]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h4,   1'b0, I0,    32'h0,   1'b0);
        tbl[7]  = mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, I1,    1'b0, 1'b0, 32'h4,   1'b1, I1,    32'h4,   1'b0);
        // decode stall for 5 cycles; a stray response in S_OUT is ignored
        tbl[8]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h4,   1'b1, I1,    32'h4,   1'b0);
        tbl[9]  = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h4,   1'b1, I1,    32'h4,   1'b0);
        tbl[10] = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b1, DB,    1'b0, 1'b0, 32'h4,   1'b1, I1,    32'h4,   1'b0);
        tbl[11] = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h4,   1'b1, I1,    32'h4,   1'b0);
        tbl[12] = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h4,   1'b1, I1,    32'h4,   1'b0);
        tbl[13] = mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8,   1'b0, I1,    32'h4,   1'b0);
        tbl[14] = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8,   1'b0, I1,    32'h4,   1'b0);
        // redirect in S_WAIT, stale response two cycles later
        tbl[15] = mk(1'b1, 1'b1, 32'h40,  1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h40,  1'b0, I1,    32'h4,   1'b0);
        tbl[16] = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h40,  1'b0, I1,    32'h4,   1'b0);
        tbl[17] = mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, DB,    1'b0, 1'b1, 32'h40,  1'b0, I1,    32'h4,   1'b0);
        tbl[18] = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h40,  1'b0, I1,    32'h4,   1'b0);
        tbl[19] = mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, I2,    1'b0, 1'b0, 32'h40,  1'b1, I2,    32'h40,  1'b0);
        // misaligned redirect in S_OUT with decode not ready
        tbl[20] = mk(1'b1, 1'b1, 32'h22,  1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h20,  1'b0, I2,    32'h40,  1'b1);
        tbl[21] = mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h20,  1'b0, I2,    32'h40,  1'b0);
        // redirect in S_REQ without and with accept, then inside S_DROP
        tbl[22] = mk(1'b1, 1'b1, 32'h80,  1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h80,  1'b0, I2,    32'h40,  1'b0);
        tbl[23] = mk(1'b1, 1'b1, 32'hC0,  1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'hC0,  1'b0, I2,    32'h40,  1'b0);
        tbl[24] = mk(1'b1, 1'b1, 32'h101, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h100, 1'b0, I2,    32'h40,  1'b1);
        tbl[25] = mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, DB,    1'b0, 1'b1, 32'h100, 1'b0, I2,    32'h40,  1'b0);
        tbl[26] = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h100, 1'b0, I2,    32'h40,  1'b0);
        // redirect in S_WAIT with same-cycle response
        tbl[27] = mk(1'b1, 1'b1, 32'h200, 1'b0, 1'b1, DB,    1'b0, 1'b1, 32'h200, 1'b0, I2,    32'h40,  1'b0);
        tbl[28] = mk(1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h200, 1'b0, I2,    32'h40,  1'b0);
        tbl[29] = mk(1'b1, 1'b0, 32'h0,   1'b0, 1'b1, I3,    1'b0, 1'b0, 32'h200, 1'b1, I3,    32'h200, 1'b0);
        // redirect beats the decode handshake increment
        tbl[30] = mk(1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h300, 1'b0, I3,    32'h200, 1'b0);

        for (int i = 0; i < NV; i++) begin
            cyc(tbl[i].rst, tbl[i].rdv, tbl[i].rdpc, tbl[i].rqr,
                tbl[i].rsv, tbl[i].rsd, tbl[i].ifr);
            chk($sformatf("row%0d req_valid", i), {31'd0, imem_req_valid}, {31'd0, tbl[i].e_rqv});
            chk($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("row%0d if_valid", i), {31'd0, if_valid}, {31'd0, tbl[i].e_ifv});
            chk($sformatf("row%0d if_instr", i), if_instr, tbl[i].e_ins);
            chk($sformatf("row%0d if_pc", i), if_pc, tbl[i].e_pc);
            chk($sformatf("row%0d misalign_err", i), {31'd0, misalign_err}, {31'd0, tbl[i].e_mis});
        end

        // PC wrap: fetch at 0xFFFF_FFFC, next address is 0
        cyc(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("wrap pre addr", imem_addr, 32'hFFFF_FFFC);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hAAAA_5555, 1'b0);
        chk("wrap if_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap if_instr", if_instr, 32'hAAAA_5555);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("wrap next addr", imem_addr, 32'h0000_0000);
        chk("wrap req_valid", {31'd0, imem_req_valid}, 32'd1);

        // one-cycle reset during S_WAIT, stale response right after release
        cyc(1'b1, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("rst pre addr", imem_addr, 32'h500);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("rst wait req_valid", {31'd0, imem_req_valid}, 32'd0);
        cyc(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("rst in if_instr", if_instr, 32'h0);
        chk("rst in if_pc", if_pc, 32'h0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, DB, 1'b0);
        chk("rst post if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst post addr", imem_addr, 32'h0000_0000);
        chk("rst post req_valid", {31'd0, imem_req_valid}, 32'd1);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("rst stale if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst stale if_instr", if_instr, 32'h0);
        chk("rst stale req_valid", {31'd0, imem_req_valid}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
